// File: rtl/data_types.sv
// Shared CDB/ALU types: tags, data words, CDB beat, ALU op codes and the dispatch issue bundle.
package data_types;

  localparam int WORD_W = 32;
  localparam int TAG_W  = 3;

  typedef logic [TAG_W-1:0]  tag_t;
  typedef logic [WORD_W-1:0] word_t;

  // Tag value meaning "no producer": operand already valid, or CDB idle.
  localparam tag_t NO_VAL = 3'd0;

  typedef struct packed {
    tag_t  tag;
    word_t val;
  } cdb_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9,
    ALU_MUL  = 4'd10
  } alu_op_t;

  typedef struct packed {
    alu_op_t op;
    tag_t    qj;
    word_t   vj;
    tag_t    qk;
    word_t   vk;
  } rs_issue_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_OPS = 2'd1,
    ST_EXEC     = 2'd2,
    ST_WAIT_CDB = 2'd3
  } rs_state_t;

endpackage

// File: rtl/rs_alu_station_core.sv
// Purely combinational integer ALU behind the reservation station.
// The multiplier exists only when RS_MUL_EN is defined; otherwise MUL yields 0.
import data_types::*;

module rs_alu_core #(
  parameter int XLEN = 32
) (
  input  alu_op_t op_i,
  input  word_t   vj_i,
  input  word_t   vk_i,
  output word_t   res_o
);

  localparam int SHW = $clog2(XLEN);

  logic [SHW-1:0] shamt;
  assign shamt = vk_i[SHW-1:0];

  always_comb begin
    res_o = '0;
    case (op_i)
      ALU_ADD:  res_o = vj_i + vk_i;
      ALU_SUB:  res_o = vj_i - vk_i;
      ALU_AND:  res_o = vj_i & vk_i;
      ALU_OR:   res_o = vj_i | vk_i;
      ALU_XOR:  res_o = vj_i ^ vk_i;
      ALU_SLL:  res_o = vj_i << shamt;
      ALU_SRL:  res_o = vj_i >> shamt;
      ALU_SRA:  res_o = $signed(vj_i) >>> shamt;
      ALU_SLT:  res_o = {{(XLEN-1){1'b0}}, ($signed(vj_i) < $signed(vk_i))};
      ALU_SLTU: res_o = {{(XLEN-1){1'b0}}, (vj_i < vk_i)};
`ifdef RS_MUL_EN
      ALU_MUL:  res_o = vj_i * vk_i;
`else
      ALU_MUL:  res_o = '0;
`endif
      default:  res_o = '0;
    endcase
  end

endmodule

// File: rtl/rs_alu_station.sv
// Single-entry reservation station with fused ALU; frees only after its own tag is seen on the CDB.
// Optional multi-cycle MUL is enabled by defining RS_MUL_EN.
import data_types::*;

module rs_alu_station #(
  parameter tag_t RS_TAG = 3'd1,
  parameter int   XLEN   = 32
) (
  input  logic      clk_i,
  input  logic      RST_i,
  input  logic      issue_valid_i,
  output logic      issue_ready_o,
  input  rs_issue_t issue_i,
  input  cdb_t      broadcast_i,
  output cdb_t      fu_res_o,
  output logic      busy_o
);

  rs_state_t  state_q, state_d;
  alu_op_t    op_q, op_d;
  tag_t       qj_q, qj_d, qk_q, qk_d;
  word_t      vj_q, vj_d, vk_q, vk_d;
  logic       rj_q, rj_d, rk_q, rk_d;
  logic [1:0] cnt_q, cnt_d;
  cdb_t       res_q, res_d;
  word_t      core_res;

  rs_alu_core #(.XLEN(XLEN)) u_core (
    .op_i  (op_q),
    .vj_i  (vj_q),
    .vk_i  (vk_q),
    .res_o (core_res)
  );

  // Next-state, operand capture and countdown
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    qj_d      = qj_q;
    qk_d      = qk_q;
    vj_d      = vj_q;
    vk_d      = vk_q;
    rj_d      = rj_q;
    rk_d      = rk_q;
    cnt_d     = cnt_q;
    res_d.tag = NO_VAL;
    res_d.val = res_q.val;
    case (state_q)
      ST_IDLE: begin
        if (issue_valid_i) begin
          op_d    = issue_i.op;
          qj_d    = issue_i.qj;
          qk_d    = issue_i.qk;
          // An operand may be satisfied by the CDB beat on the very issue edge.
          if (issue_i.qj == NO_VAL) begin
            rj_d = 1'b1;
            vj_d = issue_i.vj;
          end else if (broadcast_i.tag == issue_i.qj) begin
            rj_d = 1'b1;
            vj_d = broadcast_i.val;
          end else begin
            rj_d = 1'b0;
            vj_d = issue_i.vj;
          end
          if (issue_i.qk == NO_VAL) begin
            rk_d = 1'b1;
            vk_d = issue_i.vk;
          end else if (broadcast_i.tag == issue_i.qk) begin
            rk_d = 1'b1;
            vk_d = broadcast_i.val;
          end else begin
            rk_d = 1'b0;
            vk_d = issue_i.vk;
          end
          state_d = ST_WAIT_OPS;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_OPS: begin
        if (!rj_q && (broadcast_i.tag == qj_q)) begin
          rj_d = 1'b1;
          vj_d = broadcast_i.val;
        end else begin
          rj_d = rj_q;
        end
        if (!rk_q && (broadcast_i.tag == qk_q)) begin
          rk_d = 1'b1;
          vk_d = broadcast_i.val;
        end else begin
          rk_d = rk_q;
        end
        if (rj_q && rk_q) begin
`ifdef RS_MUL_EN
          cnt_d = (op_q == ALU_MUL) ? 2'd2 : 2'd0;
`else
          cnt_d = 2'd0;
`endif
          state_d = ST_EXEC;
        end else begin
          state_d = ST_WAIT_OPS;
        end
      end
      ST_EXEC: begin
        if (cnt_q == 2'd0) begin
          res_d.tag = RS_TAG;
          res_d.val = core_res;
          state_d   = ST_WAIT_CDB;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      ST_WAIT_CDB: begin
        if (broadcast_i.tag == RS_TAG) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT_CDB;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (RST_i) begin
      state_q <= ST_IDLE;
      op_q    <= ALU_ADD;
      qj_q    <= NO_VAL;
      qk_q    <= NO_VAL;
      vj_q    <= '0;
      vk_q    <= '0;
      rj_q    <= 1'b0;
      rk_q    <= 1'b0;
      cnt_q   <= 2'd0;
      res_q   <= '{tag: NO_VAL, val: '0};
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      qj_q    <= qj_d;
      qk_q    <= qk_d;
      vj_q    <= vj_d;
      vk_q    <= vk_d;
      rj_q    <= rj_d;
      rk_q    <= rk_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  // Outputs depend only on registers and reset, never on broadcast_i
  always_comb begin
    issue_ready_o = (state_q == ST_IDLE) && !RST_i;
    busy_o        = (state_q != ST_IDLE);
    fu_res_o      = res_q;
  end

endmodule

// File: tb/tb_rs_alu_station.sv
// Scoreboard bench for rs_alu_station: stimulus pushes expected {value, cycle}, a negedge monitor checks results.
import data_types::*;

module tb_rs_alu_station;

  localparam tag_t TAG = 3'd1;
`ifdef RS_MUL_EN
  localparam int MUL_EXTRA = 2;
`else
  localparam int MUL_EXTRA = 0;
`endif

  logic      clk_i = 1'b0;
  logic      RST_i = 1'b1;
  logic      issue_valid_i = 1'b0;
  logic      issue_ready_o;
  rs_issue_t issue_i = '0;
  cdb_t      broadcast_i = '0;
  cdb_t      fu_res_o;
  logic      busy_o;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  word_t exp_val_q[$];
  int    exp_cyc_q[$];

  rs_alu_station #(.RS_TAG(TAG), .XLEN(32)) dut (
    .clk_i         (clk_i),
    .RST_i         (RST_i),
    .issue_valid_i (issue_valid_i),
    .issue_ready_o (issue_ready_o),
    .issue_i       (issue_i),
    .broadcast_i   (broadcast_i),
    .fu_res_o      (fu_res_o),
    .busy_o        (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Edge counter; value k is visible after posedge k
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Result monitor: whenever the station presents its tag, pop and compare value and cycle
  always @(negedge clk_i) begin
    if (!RST_i && fu_res_o.tag == TAG) begin
      if (exp_val_q.size() == 0) begin
        n_assert++;
        n_fail++;
        $display("FAIL unexpected_result: got 0x%08h with nothing expected (cyc %0d)", fu_res_o.val, cyc);
      end else begin
        check("result_val", fu_res_o.val, exp_val_q.pop_front());
        check("result_cycle", cyc, exp_cyc_q.pop_front());
      end
    end
  end

  // A result registered at edge c is visible at the negedge where cyc == c
  task automatic push(input word_t v, input int c);
    exp_val_q.push_back(v);
    exp_cyc_q.push_back(c);
  endtask

  task automatic do_issue(input alu_op_t op, input tag_t qj, input word_t vj,
                          input tag_t qk, input word_t vk,
                          input tag_t bt, input word_t bv, input bit hold, output int t);
    int n;
    @(negedge clk_i);
    issue_valid_i = 1'b1;
    issue_i.op = op; issue_i.qj = qj; issue_i.vj = vj; issue_i.qk = qk; issue_i.vk = vk;
    broadcast_i.tag = bt; broadcast_i.val = bv;
    n = 0;
    while (!issue_ready_o && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    check("issue_ready", {31'd0, issue_ready_o}, 32'd1);
    @(posedge clk_i);
    #1;
    t = cyc;
    if (!hold) issue_valid_i = 1'b0;
    broadcast_i.tag = NO_VAL; broadcast_i.val = 32'd0;
  endtask

  task automatic bcast(input tag_t bt, input word_t bv, output int c);
    @(negedge clk_i);
    broadcast_i.tag = bt; broadcast_i.val = bv;
    @(posedge clk_i);
    #1;
    c = cyc;
    broadcast_i.tag = NO_VAL; broadcast_i.val = 32'd0;
  endtask

  task automatic wait_res();
    int n;
    n = 0;
    @(negedge clk_i);
    while (fu_res_o.tag != TAG && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    if (fu_res_o.tag != TAG) begin
      n_assert++;
      n_fail++;
      $display("FAIL result_timeout: no result tag within 20 cycles (cyc %0d)", cyc);
    end
  endtask

  task automatic free_station();
    int c;
    bcast(TAG, 32'd0, c);
    @(negedge clk_i);
    check("freed_busy", {31'd0, busy_o}, 32'd0);
  endtask

  typedef struct {
    alu_op_t op;
    word_t   vj;
    word_t   vk;
    word_t   exp;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int t, c;
    vecs[0] = '{ALU_XOR,  32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFF00_EDCB};
    vecs[1] = '{ALU_AND,  32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234};
    vecs[2] = '{ALU_OR,   32'hF000_0001, 32'h0000_0F00, 32'hF000_0F01};
    vecs[3] = '{ALU_SRL,  32'h8000_0000, 32'h0000_0004, 32'h0800_0000};
    vecs[4] = '{ALU_SRA,  32'h8000_0000, 32'h0000_0024, 32'hF800_0000};
    vecs[5] = '{ALU_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001};
    vecs[6] = '{ALU_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
    vecs[7] = '{ALU_SUB,  32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF};

    // Reset state
    repeat (3) @(negedge clk_i);
    check("rst_ready", {31'd0, issue_ready_o}, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_tag", {29'd0, fu_res_o.tag}, {29'd0, NO_VAL});
    check("rst_val", fu_res_o.val, 32'd0);
    RST_i = 1'b0;

    // ADD wraps modulo 2^32; tag lasts one cycle, busy until own tag on CDB
    do_issue(ALU_ADD, NO_VAL, 32'hFFFF_FFFF, NO_VAL, 32'd2, NO_VAL, 32'd0, 1'b0, t);
    push(32'h1, t + 2);
    wait_res();
    @(negedge clk_i);
    check("add_tag_drop", {29'd0, fu_res_o.tag}, {29'd0, NO_VAL});
    check("add_busy_hold", {31'd0, busy_o}, 32'd1);
    @(negedge clk_i);
    check("add_busy_hold2", {31'd0, busy_o}, 32'd1);
    free_station();

    // SUB waiting on tag 3 for both operands; a stray own-tag beat in WAIT_OPS is ignored
    do_issue(ALU_SUB, 3'd3, 32'd7, 3'd3, 32'd99, NO_VAL, 32'd0, 1'b0, t);
    bcast(TAG, 32'h5555, c);
    @(negedge clk_i);
    check("stray_busy", {31'd0, busy_o}, 32'd1);
    check("stray_ready", {31'd0, issue_ready_o}, 32'd0);
    bcast(3'd3, 32'd10, c);
    push(32'd0, c + 2);
    wait_res();
    free_station();

    // One operand from CDB, other ready at issue
    do_issue(ALU_SUB, 3'd5, 32'd0, NO_VAL, 32'd3, NO_VAL, 32'd0, 1'b0, t);
    bcast(3'd5, 32'd20, c);
    push(32'd17, c + 2);
    wait_res();
    free_station();

    // SLL with vk captured from the CDB on the issue edge; shift uses low 5 bits of 0x24
    do_issue(ALU_SLL, NO_VAL, 32'd1, 3'd4, 32'd0, 3'd4, 32'h24, 1'b0, t);
    push(32'h10, t + 2);
    wait_res();
    free_station();

    // Remaining ALU ops, all operands ready at issue
    for (int i = 0; i < 8; i++) begin
      do_issue(vecs[i].op, NO_VAL, vecs[i].vj, NO_VAL, vecs[i].vk, NO_VAL, 32'd0, 1'b0, t);
      push(vecs[i].exp, t + 2);
      wait_res();
      free_station();
    end

    // MUL: low 32 bits, extra latency only with the multiplier built
    do_issue(ALU_MUL, NO_VAL, 32'h1_0000, NO_VAL, 32'h1_0000, NO_VAL, 32'd0, 1'b0, t);
    push(32'd0, t + 2 + MUL_EXTRA);
    wait_res();
    free_station();
    do_issue(ALU_MUL, NO_VAL, 32'd3, NO_VAL, 32'd5, NO_VAL, 32'd0, 1'b0, t);
`ifdef RS_MUL_EN
    push(32'd15, t + 2 + MUL_EXTRA);
`else
    push(32'd0, t + 2 + MUL_EXTRA);
`endif
    wait_res();
    free_station();

    // Held issue_valid: no second accept until the cycle after the own-tag broadcast
    do_issue(ALU_ADD, NO_VAL, 32'd40, NO_VAL, 32'd2, NO_VAL, 32'd0, 1'b1, t);
    push(32'd42, t + 2);
    wait_res();
    check("hold_ready_wcdb", {31'd0, issue_ready_o}, 32'd0);
    @(negedge clk_i);
    check("hold_ready_wcdb2", {31'd0, issue_ready_o}, 32'd0);
    bcast(TAG, 32'd0, c);
    @(negedge clk_i);
    check("hold_ready_after", {31'd0, issue_ready_o}, 32'd1);
    @(posedge clk_i);
    #1;
    push(32'd42, cyc + 2);
    issue_valid_i = 1'b0;
    wait_res();
    free_station();

    // Reset during EXEC of a MUL drops the instruction
    do_issue(ALU_MUL, NO_VAL, 32'd6, NO_VAL, 32'd7, NO_VAL, 32'd0, 1'b0, t);
    @(negedge clk_i);
    @(negedge clk_i);
    RST_i = 1'b1;
    @(negedge clk_i);
    check("midrst_busy", {31'd0, busy_o}, 32'd0);
    check("midrst_tag", {29'd0, fu_res_o.tag}, {29'd0, NO_VAL});
    check("midrst_val", fu_res_o.val, 32'd0);
    check("midrst_ready", {31'd0, issue_ready_o}, 32'd0);
    RST_i = 1'b0;
    #1;
    check("postrst_ready", {31'd0, issue_ready_o}, 32'd1);
    repeat (6) @(negedge clk_i);
    check("postrst_busy", {31'd0, busy_o}, 32'd0);

    check("scoreboard_empty", exp_val_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/rs_alu_station.md
# rs_alu_station

Single-entry reservation station fused with a small integer ALU; one instance per functional-unit slot. It sits directly upstream of the CDB broadcaster and feeds one `fu_res_i[i]` lane of it. It accepts an instruction from dispatch, snoops the CDB for missing operands, executes, and presents a one-cycle tagged result. It frees itself only after its own tag appears on the CDB, which guarantees the broadcaster's holding register for this lane is never overwritten while valid.

## Interface
- `RS_TAG`, default 1: this station's CDB tag (`tag_t`); must differ from `NO_VAL`.
- `XLEN`, default 32: datapath width; matches `word_t` in the shared package.

- `clk_i` input 1: clock.
- `RST_i` input 1: reset, synchronous, active-high.
- `issue_valid_i` input 1: dispatch offers an instruction.
- `issue_ready_o` output 1: station can accept; issue fires on the edge where valid and ready are both high.
- `issue_i` input `rs_issue_t`: fields `op`, `qj`, `vj`, `qk`, `vk`; a `q*` of `NO_VAL` means the matching `v*` is valid.
- `broadcast_i` input `cdb_t`: CDB from the broadcaster; tag `NO_VAL` means idle.
- `fu_res_o` output `cdb_t`: result to broadcaster lane; tag is `RS_TAG` for exactly one cycle per instruction, otherwise `NO_VAL`.
- `busy_o` output 1: state is not IDLE.

## Operation
- States and transitions:
  - IDLE: `issue_ready_o`=1. On issue, latch op/operands → WAIT_OPS.
  - WAIT_OPS: if both operands are ready, load the latency counter (0 for ALU ops, 2 for MUL) → EXEC.
  - EXEC: if counter==0, register the result into `fu_res_o` with tag `RS_TAG` → WAIT_CDB; otherwise decrement.
  - WAIT_CDB: when `broadcast_i.tag==RS_TAG` → IDLE.
- Operand capture:
  - At issue, an operand is ready if its `q==NO_VAL`, or if `broadcast_i.tag==q`; in the latter case `broadcast_i.val` is captured in the same edge.
  - In WAIT_OPS, any not-ready operand whose stored tag equals `broadcast_i.tag` captures `broadcast_i.val`.
  - Both operands may capture from the same broadcast.
  - Snooping stops outside WAIT_OPS and the issue edge.
- Ops (`alu_op_t`): ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU, MUL.
  - Results are modulo 2^XLEN.
  - Shifts use `vk[$clog2(XLEN)-1:0]`.
  - SLT/SLTU yield 0 or 1.
  - MUL returns the low XLEN bits.
- `fu_res_o.tag` returns to `NO_VAL` the cycle after the result cycle; `val` is don't-care when the tag is `NO_VAL`.
- A broadcast of `RS_TAG` seen in any state other than WAIT_CDB is ignored.
- Reset, including mid-operation: state → IDLE, operands dropped, `fu_res_o.tag`=`NO_VAL`, `fu_res_o.val`=0, `busy_o`=0. `issue_ready_o` is 0 in any cycle where `RST_i` is high.

## Timing
- Issue accepted at edge T, operands ready: WAIT_OPS in T+1, EXEC in T+2, `fu_res_o.tag==RS_TAG` in cycle T+3.
- MUL: result appears in cycle T+5.
- Operand broadcast in cycle B, with the other operand already ready: result in cycle B+3 (B+5 for MUL).
- Next issue is accepted no earlier than the cycle after `broadcast_i.tag==RS_TAG`.
- With the broadcaster, minimum issue-to-reissue is 6 cycles.
- No combinational path from `broadcast_i` to any output.

## Configuration
- `RS_MUL_EN`:
  - Defined: MUL is supported with a 2-cycle countdown in EXEC.
  - Undefined: no multiplier is built; a MUL op completes with ALU latency (counter 0) and result 0.
  - All other ops are identical in both builds.

## Structure
- Package `data_types` gains `alu_op_t` (enum) and `rs_issue_t` (packed struct).
- Existing `cdb_t`, `tag_t`, `word_t`, and `NO_VAL` are reused unchanged.
- One sub-module: `rs_alu_core`, a purely combinational op/vj/vk → result block. Under `RS_MUL_EN` its MUL output is registered through the station's EXEC stages.
- FSM, operand capture and counter stay in `rs_alu_station`.

## Test plan
- Reset mid-EXEC of a MUL → next cycle: `busy_o`=0, `fu_res_o.tag`=`NO_VAL`; `issue_ready_o`=1 after `RST_i` falls.
- Issue ADD, vj=0xFFFFFFFF, vk=2, both q=`NO_VAL`, at edge T → cycle T+3: `fu_res_o`={`RS_TAG`, 0x1}; T+4: tag `NO_VAL`; `busy_o` stays high until broadcast of `RS_TAG`.
- Issue SUB with qj=3, qk=3; broadcast {3, 10} two cycles later → both operands captured; result {`RS_TAG`, 0} three cycles after the broadcast.
- Issue SLL with qk=4 while `broadcast_i`={4, 0x24} in the same cycle, vj=1 → issue-cycle capture; result 0x10 at T+3.
- With `RS_MUL_EN`: MUL 0x10000×0x10000 → result 0 at T+5. Without the macro: result 0 at T+3.
- Hold `issue_valid_i` high through a result → no second accept until the cycle after `broadcast_i.tag==RS_TAG`. A stray `RS_TAG` broadcast during WAIT_OPS causes no state change.
